// File: rtl/encoder8_3_seq_if.sv
// encoder8_3_seq_if: groups the vector-in and index-out handshakes of encoder8_3_seq.
// Ports: in_vec/in_valid/in_ready (vector in), out1..out3/out_none/out_last/out_valid/out_ready (beats out).
// master = upstream producer and downstream consumer side; slave = the encoder itself.
interface encoder8_3_seq_if;
  logic [7:0] in_vec;
  logic       in_valid;
  logic       in_ready;
  logic       out1;
  logic       out2;
  logic       out3;
  logic       out_none;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_vec, in_valid, out_ready,
    input  in_ready, out1, out2, out3, out_none, out_last, out_valid
  );

  modport slave (
    input  in_vec, in_valid, out_ready,
    output in_ready, out1, out2, out3, out_none, out_last, out_valid
  );
endinterface

// File: rtl/encoder8_3_seq.sv
// encoder8_3_seq: emits the 3-bit index of every set bit of an accepted 8-bit vector, one per beat.
// Latency: first beat 1 cycle after accept; one beat per cycle; in_ready back the cycle after the last beat.
// Backpressure: out_ready low holds the current beat and pending vector stable; no new vector while emitting.
// Ports: sys_clk, sys_rst (async, active-high), bus (slave modport of encoder8_3_seq_if).
module encoder8_3_seq #(
  parameter bit PRIORITY_HIGH = 1'b0  // 0: lowest set bit first, 1: highest set bit first
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  encoder8_3_seq_if.slave     bus
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic [2:0] idx_q, idx_d;
  logic       none_q, none_d;
  logic       last_q, last_d;
  logic       valid_q, valid_d;
  logic [7:0] pend_clr;

  // Index of the first set bit in scan order; 0 for an all-zero vector.
  function automatic logic [2:0] scan(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (PRIORITY_HIGH) begin
      // ascending walk: the last hit is the highest set bit
      for (int i = 0; i < 8; i++) begin
        if (v[i]) idx = 3'(i);
      end
    end else begin
      // descending walk: the last hit is the lowest set bit
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic one_hot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  // Pending vector with the bit of the current beat removed.
  assign pend_clr = pend_q & ~(8'd1 << idx_q);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    none_d  = none_q;
    last_d  = last_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // first beat is computed straight from the incoming vector so it
          // is registered on the accept edge
          state_d = EMIT;
          pend_d  = bus.in_vec;
          idx_d   = scan(bus.in_vec);
          none_d  = (bus.in_vec == 8'd0);
          last_d  = (bus.in_vec == 8'd0) || one_hot(bus.in_vec);
          valid_d = 1'b1;
        end
      end
      EMIT: begin
        if (valid_q && bus.out_ready) begin
          pend_d = pend_clr;
          if (last_q) begin
            state_d = IDLE;
            idx_d   = 3'd0;
            none_d  = 1'b0;
            last_d  = 1'b0;
            valid_d = 1'b0;
          end else begin
            idx_d   = scan(pend_clr);
            none_d  = 1'b0;
            last_d  = one_hot(pend_clr);
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      pend_q  <= 8'd0;
      idx_q   <= 3'd0;
      none_q  <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      none_q  <= none_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out1      = idx_q[0];
  assign bus.out2      = idx_q[1];
  assign bus.out3      = idx_q[2];
  assign bus.out_none  = none_q;
  assign bus.out_last  = last_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_encoder8_3_seq.sv
// tb_encoder8_3_seq: drives both scan orders in lockstep and scoreboards every output beat.
module tb_encoder8_3_seq;

  logic       sys_clk;
  logic       sys_rst;
  logic [7:0] in_vec;
  logic       in_valid;
  logic       out_ready;

  int tests_run;
  int tests_failed;

  logic [4:0] exp_lo[$];
  logic [4:0] exp_hi[$];
  logic [7:0] vec_lo[$];
  logic [7:0] vec_hi[$];
  logic [7:0] acc_lo;
  logic [7:0] acc_hi;

  encoder8_3_seq_if b_lo ();
  encoder8_3_seq_if b_hi ();

  assign b_lo.in_vec    = in_vec;
  assign b_lo.in_valid  = in_valid;
  assign b_lo.out_ready = out_ready;
  assign b_hi.in_vec    = in_vec;
  assign b_hi.in_valid  = in_valid;
  assign b_hi.out_ready = out_ready;

  encoder8_3_seq #(.PRIORITY_HIGH(1'b0)) u_lo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (b_lo)
  );

  encoder8_3_seq #(.PRIORITY_HIGH(1'b1)) u_hi (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (b_hi)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // One clock: sample at the falling edge (scoreboard push on accept,
  // pop and compare on beat completion), then return 1 time unit after the
  // rising edge so the caller can drive the next inputs.
  task automatic tick();
    logic [4:0] got;
    logic [4:0] e;
    int n;
    int k;
    @(negedge sys_clk);
    if (!sys_rst) begin
      if (in_valid && b_lo.in_ready) begin
        n = $countones(in_vec);
        if (n == 0) begin
          exp_lo.push_back({1'b1, 1'b1, 3'd0});
          exp_hi.push_back({1'b1, 1'b1, 3'd0});
        end else begin
          k = 0;
          for (int i = 0; i < 8; i++) begin
            if (in_vec[i]) begin
              k++;
              exp_lo.push_back({(k == n), 1'b0, 3'(i)});
            end
          end
          k = 0;
          for (int i = 7; i >= 0; i--) begin
            if (in_vec[i]) begin
              k++;
              exp_hi.push_back({(k == n), 1'b0, 3'(i)});
            end
          end
        end
        vec_lo.push_back(in_vec);
        vec_hi.push_back(in_vec);
      end
      if (b_lo.out_valid && out_ready) begin
        got = {b_lo.out_last, b_lo.out_none, b_lo.out3, b_lo.out2, b_lo.out1};
        tests_run++;
        if (exp_lo.size() == 0) begin
          tests_failed++;
          $display("FAIL lo_unexpected_beat: got %b, required no beat", got);
        end else begin
          e = exp_lo.pop_front();
          if (got !== e) begin
            tests_failed++;
            $display("FAIL lo_beat {last,none,idx}: got %b, required %b", got, e);
          end
        end
        if (!b_lo.out_none) acc_lo = acc_lo | (8'd1 << got[2:0]);
        if (b_lo.out_last && vec_lo.size() != 0) begin
          e[0] = 1'b0;
          tests_run++;
          if (acc_lo !== vec_lo[0]) begin
            tests_failed++;
            $display("FAIL lo_or_reduce: got %h, required %h", acc_lo, vec_lo[0]);
          end
          void'(vec_lo.pop_front());
          acc_lo = 8'd0;
        end
      end
      if (b_hi.out_valid && out_ready) begin
        got = {b_hi.out_last, b_hi.out_none, b_hi.out3, b_hi.out2, b_hi.out1};
        tests_run++;
        if (exp_hi.size() == 0) begin
          tests_failed++;
          $display("FAIL hi_unexpected_beat: got %b, required no beat", got);
        end else begin
          e = exp_hi.pop_front();
          if (got !== e) begin
            tests_failed++;
            $display("FAIL hi_beat {last,none,idx}: got %b, required %b", got, e);
          end
        end
        if (!b_hi.out_none) acc_hi = acc_hi | (8'd1 << got[2:0]);
        if (b_hi.out_last && vec_hi.size() != 0) begin
          tests_run++;
          if (acc_hi !== vec_hi[0]) begin
            tests_failed++;
            $display("FAIL hi_or_reduce: got %h, required %h", acc_hi, vec_hi[0]);
          end
          void'(vec_hi.pop_front());
          acc_hi = 8'd0;
        end
      end
    end
    @(posedge sys_clk);
    #1;
  endtask

  // Present one vector for a single accept edge (caller ensures in_ready=1).
  task automatic send(input logic [7:0] v);
    in_vec   = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Run with out_ready=1 until every expected beat is out and both are idle.
  task automatic drain();
    int guard;
    out_ready = 1'b1;
    guard = 0;
    while ((exp_lo.size() != 0 || exp_hi.size() != 0 || b_lo.out_valid || b_hi.out_valid)
           && guard < 64) begin
      tick();
      guard++;
    end
    if (guard >= 64) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain_timeout: %0d lo / %0d hi beats still expected, required 0",
               exp_lo.size(), exp_hi.size());
    end
  endtask

  task automatic test_reset();
    sys_rst   = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_vec    = 8'($urandom);
    acc_lo    = 8'd0;
    acc_hi    = 8'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge sys_clk);
      tests_run++;
      if ({b_lo.in_ready, b_lo.out_valid, b_lo.out3, b_lo.out2, b_lo.out1, b_lo.out_none, b_lo.out_last} !== 7'b1000000) begin
        tests_failed++;
        $display("FAIL reset_lo: got %b, required 1000000",
                 {b_lo.in_ready, b_lo.out_valid, b_lo.out3, b_lo.out2, b_lo.out1, b_lo.out_none, b_lo.out_last});
      end
      tests_run++;
      if ({b_hi.in_ready, b_hi.out_valid, b_hi.out3, b_hi.out2, b_hi.out1, b_hi.out_none, b_hi.out_last} !== 7'b1000000) begin
        tests_failed++;
        $display("FAIL reset_hi: got %b, required 1000000",
                 {b_hi.in_ready, b_hi.out_valid, b_hi.out3, b_hi.out2, b_hi.out1, b_hi.out_none, b_hi.out_last});
      end
      in_vec = 8'($urandom);
    end
    @(posedge sys_clk);
    #1;
    sys_rst  = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_one_hot();
    out_ready = 1'b1;
    send(8'b0000_0100);
    tests_run++;
    if ({b_lo.out_valid, b_lo.out_last, b_lo.out_none, b_lo.out3, b_lo.out2, b_lo.out1} !== 6'b110010) begin
      tests_failed++;
      $display("FAIL one_hot_first_beat: got %b, required 110010",
               {b_lo.out_valid, b_lo.out_last, b_lo.out_none, b_lo.out3, b_lo.out2, b_lo.out1});
    end
    tick();
    tests_run++;
    if (b_lo.in_ready !== 1'b1 || b_lo.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL one_hot_idle_after: in_ready=%b out_valid=%b, required 1 0",
               b_lo.in_ready, b_lo.out_valid);
    end
    drain();
  endtask

  task automatic test_multi_hot();
    out_ready = 1'b1;
    send(8'b1001_0010);
    tests_run++;
    if ({b_lo.out3, b_lo.out2, b_lo.out1} !== 3'd1 || {b_hi.out3, b_hi.out2, b_hi.out1} !== 3'd7) begin
      tests_failed++;
      $display("FAIL multi_first_idx: lo=%0d hi=%0d, required lo=1 hi=7",
               {b_lo.out3, b_lo.out2, b_lo.out1}, {b_hi.out3, b_hi.out2, b_hi.out1});
    end
    tick();
    tick();
    tick();
    tests_run++;
    if (b_lo.in_ready !== 1'b1 || b_hi.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL multi_three_cycles: in_ready lo=%b hi=%b, required 1 1",
               b_lo.in_ready, b_hi.in_ready);
    end
    drain();
  endtask

  task automatic test_zero();
    out_ready = 1'b1;
    send(8'h00);
    tests_run++;
    if ({b_lo.out_valid, b_lo.out_none, b_lo.out_last, b_lo.out3, b_lo.out2, b_lo.out1} !== 6'b111000) begin
      tests_failed++;
      $display("FAIL zero_beat: got %b, required 111000",
               {b_lo.out_valid, b_lo.out_none, b_lo.out_last, b_lo.out3, b_lo.out2, b_lo.out1});
    end
    tick();
    tests_run++;
    if (b_hi.in_ready !== 1'b1 || b_hi.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_idle_after: in_ready=%b out_valid=%b, required 1 0",
               b_hi.in_ready, b_hi.out_valid);
    end
    drain();
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    send(8'b0110_0000);
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if ({b_lo.out_valid, b_lo.in_ready, b_lo.out_last, b_lo.out3, b_lo.out2, b_lo.out1} !== 6'b100101 ||
          {b_hi.out3, b_hi.out2, b_hi.out1} !== 3'd6) begin
        tests_failed++;
        $display("FAIL hold_cycle%0d: lo {vld,rdy,last,idx}=%b hi idx=%0d, required 100101 and 6",
                 c, {b_lo.out_valid, b_lo.in_ready, b_lo.out_last, b_lo.out3, b_lo.out2, b_lo.out1},
                 {b_hi.out3, b_hi.out2, b_hi.out1});
      end
      // busy-time offer of 8'hFF must be ignored
      in_vec   = 8'hFF;
      in_valid = (c == 1 || c == 2);
      tick();
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(8'hFF);
    tick();
    tick();
    tick();
    #1;
    sys_rst = 1'b1;
    #1;
    tests_run++;
    if (b_lo.out_valid !== 1'b0 || b_lo.in_ready !== 1'b1 || b_hi.out_valid !== 1'b0 || b_hi.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_reset: lo vld/rdy=%b%b hi vld/rdy=%b%b, required 01 01",
               b_lo.out_valid, b_lo.in_ready, b_hi.out_valid, b_hi.in_ready);
    end
    exp_lo.delete();
    exp_hi.delete();
    vec_lo.delete();
    vec_hi.delete();
    acc_lo = 8'd0;
    acc_hi = 8'd0;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    send(8'b0000_0001);
    tests_run++;
    if ({b_lo.out_valid, b_lo.out_last, b_lo.out3, b_lo.out2, b_lo.out1} !== 5'b11000 ||
        {b_hi.out_last, b_hi.out3, b_hi.out2, b_hi.out1} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL after_reset_beat: lo %b hi %b, required 11000 1000",
               {b_lo.out_valid, b_lo.out_last, b_lo.out3, b_lo.out2, b_lo.out1},
               {b_hi.out_last, b_hi.out3, b_hi.out2, b_hi.out1});
    end
    drain();
    tick();
    tick();
  endtask

  task automatic test_random();
    int guard;
    for (int v = 0; v < 150; v++) begin
      guard = 0;
      while (!b_lo.in_ready && guard < 100) begin
        out_ready = 1'($urandom);
        in_valid  = 1'($urandom);
        in_vec    = 8'($urandom);
        tick();
        guard++;
      end
      if (guard >= 100) begin
        tests_run++;
        tests_failed++;
        $display("FAIL random_in_ready_timeout: in_ready=%b, required 1", b_lo.in_ready);
      end
      out_ready = 1'($urandom);
      case ($urandom_range(0, 5))
        0:       send(8'h00);
        1:       send(8'd1 << $urandom_range(0, 7));
        default: send(8'($urandom));
      endcase
    end
    drain();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_one_hot();
    test_multi_hot();
    test_zero();
    test_back_pressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
